// File: rtl/ftsd_scan_ctl.sv
// Four-digit seven-segment scan controller.
// Each digit slot begins with a blanking window and then shows the digit.
// A new value is captured into a pending register and copied into the display
// register only at the frame boundary, so a frame never shows a mix of values.
module ftsd_scan_ctl #(
  parameter int CNT_W     = 20,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  ftsd_ctl,
  output logic [7:0]  seg,
  output logic        ack,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] BLK  = CNT_W'(BLANK_CYC);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t            state, nstate;
  logic [CNT_W-1:0]  cnt, ncnt;
  logic [1:0]        dig, ndig;
  logic              started;
  logic [15:0]       disp, pend;
  logic [3:0]        disp_dp, pend_dp;
  logic              pend_valid;
  logic              wrap, commit;
  logic [3:0]        nib;
  logic [15:0]       hi;
  logic              blank_dig;
  logic [6:0]        glyph;

  // Next slot position and FSM state. Outputs are registered from these next
  // values so the output in a cycle always matches that cycle's counter.
  // Until the first edge after reset the counter is held at 0 so that edge
  // opens the first frame with counter 0.
  always_comb begin
    wrap   = (cnt == LAST);
    ncnt   = cnt + CNT_W'(1);
    ndig   = dig;
    nstate = state;
    if (!started) begin
      ncnt = '0;
      ndig = 2'd0;
    end else if (wrap) begin
      ncnt = '0;
      ndig = dig + 2'd1;
    end
    case (state)
      BLANK:   nstate = (started && ncnt == BLK) ? SHOW : BLANK;
      SHOW:    nstate = (ncnt == '0) ? BLANK : SHOW;
      default: nstate = BLANK;
    endcase
    // A load landing on the boundary edge keeps the new value pending instead
    commit = started && wrap && (dig == 2'd3) && pend_valid && !load;
  end

  // Glyph and leading-zero decision for the digit about to be shown
  always_comb begin
    nib       = disp[{ndig, 2'b00} +: 4];
    hi        = disp >> {ndig, 2'b00};
    blank_dig = lz_en && (ndig != 2'd0) && (hi == 16'h0000);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  // Scan state, pending/display registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      dig         <= 2'd0;
      started     <= 1'b0;
      disp        <= 16'h0000;
      disp_dp     <= 4'b0000;
      pend        <= 16'h0000;
      pend_dp     <= 4'b0000;
      pend_valid  <= 1'b0;
      ftsd_ctl    <= 4'b1111;
      seg         <= 8'hFF;
      ack         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      started     <= 1'b1;
      cnt         <= ncnt;
      dig         <= ndig;
      state       <= nstate;
      frame_start <= (ncnt == '0) && (ndig == 2'd0);
      ack         <= commit;
      if (load) begin
        pend       <= data;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      if (commit) begin
        disp    <= pend;
        disp_dp <= pend_dp;
      end
      if (nstate == SHOW && !blank_dig) begin
        ftsd_ctl <= ~(4'b0001 << ndig);
        seg      <= {~disp_dp[ndig], glyph};
      end else begin
        ftsd_ctl <= 4'b1111;
        seg      <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_ftsd_scan_ctl.sv
// Bench for ftsd_scan_ctl: a cycle-indexed reference model (slot/digit from
// the cycle number since reset release) checked every cycle, plus literal
// expectations at hand-picked cycles.
module tb_ftsd_scan_ctl;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  ftsd_ctl;
  logic [7:0]  seg;
  logic        ack, frame_start;

  int errors = 0;
  int checks = 0;
  int acks   = 0;

  ftsd_scan_ctl #(.CNT_W(3), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
    .lz_en(lz_en), .ftsd_ctl(ftsd_ctl), .seg(seg), .ack(ack),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [6:0]  segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          mk = 0;
  logic [15:0] mdisp = 16'h0, mpend = 16'h0;
  logic [3:0]  mdp = 4'h0, mpdp = 4'h0;
  logic        mpv = 1'b0;
  logic [3:0]  e_ctl = 4'hF;
  logic [7:0]  e_seg = 8'hFF;
  logic        e_ack = 1'b0, e_fs = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, mk, act, exp);
    end
  endtask

  // Model: cycle k after release sits at counter (k-1)%SLOT of digit ((k-1)/SLOT)%4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk = 0; mdisp = 16'h0; mdp = 4'h0; mpv = 1'b0;
      e_ctl = 4'hF; e_seg = 8'hFF; e_ack = 1'b0; e_fs = 1'b0;
    end else begin
      int c, d;
      logic [15:0] hi;
      logic [3:0] nib;
      mk++;
      c = (mk - 1) % SLOT;
      d = ((mk - 1) / SLOT) % 4;
      e_ack = 1'b0;
      if (mk > 1 && c == 0 && d == 0 && mpv && !load) begin
        mdisp = mpend; mdp = mpdp; mpv = 1'b0; e_ack = 1'b1;
      end
      if (load) begin
        mpend = data; mpdp = dp_in; mpv = 1'b1;
      end
      e_fs = (c == 0 && d == 0);
      hi   = mdisp >> (4 * d);
      nib  = hi[3:0];
      if (c < BLANK || (lz_en && d != 0 && hi == 16'h0)) begin
        e_ctl = 4'hF; e_seg = 8'hFF;
      end else begin
        e_ctl = ~(4'b0001 << d);
        e_seg = {~mdp[d], segtab[nib]};
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("ctl", {12'h0, ftsd_ctl}, {12'h0, e_ctl});
    chk("seg", {8'h0, seg}, {8'h0, e_seg});
    chk("ack", {15'h0, ack}, {15'h0, e_ack});
    chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
    if (ack) acks++;
  end

  task automatic go(input int kt);
    int g = 0;
    while (mk < kt && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (mk != kt) chk("go_timeout", 16'(mk), 16'(kt));
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] p);
    load = 1'b1; data = v; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] c, input logic [7:0] s);
    chk({name, "_ctl"}, {12'h0, ftsd_ctl}, {12'h0, c});
    chk({name, "_seg"}, {8'h0, seg}, {8'h0, s});
  endtask

  initial begin
    int a0, g;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    lit("rst", 4'hF, 8'hFF);
    chk("rst_ack", {15'h0, ack}, 16'h0);
    chk("rst_fs", {15'h0, frame_start}, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // first cycle after release
    lit("first", 4'hF, 8'hFF);
    chk("first_fs", {15'h0, frame_start}, 16'h1);
    go(3);  lit("d0_zero", 4'hE, 8'hC0);
    go(8);  lit("d0_last", 4'hE, 8'hC0);

    // scan order with 1234, dp on digit 0
    go(5 + 3 * SLOT - SLOT);  // still in frame 0
    pulse_load(16'h1234, 4'b0001);
    go(33); chk("ack_1234", {15'h0, ack}, 16'h1);
    chk("fs_frame1", {15'h0, frame_start}, 16'h1);
    go(35); lit("s_d0", 4'hE, 8'h19);
    go(43); lit("s_d1", 4'hD, 8'hB0);
    go(51); lit("s_d2", 4'hB, 8'hA4);
    go(59); lit("s_d3", 4'h7, 8'hF9);

    // leading-zero blanking
    lz_en = 1'b1;
    go(60); pulse_load(16'h0050, 4'b0000);
    go(67); lit("lz_d0", 4'hE, 8'hC0);
    go(75); lit("lz_d1", 4'hD, 8'h92);
    go(83); lit("lz_d2", 4'hF, 8'hFF);
    go(91); lit("lz_d3", 4'hF, 8'hFF);
    go(96); lit("lz_d3_end", 4'hF, 8'hFF);

    // overwrite within a frame: one ack, last value shown
    a0 = acks;
    go(100); pulse_load(16'h1111, 4'b0000);
    go(110); pulse_load(16'h2222, 4'b0000);
    go(131); lit("ow_d0", 4'hE, 8'hA4);
    go(155); lit("ow_d3", 4'h7, 8'hA4);

    // load in the boundary cycle with nothing pending
    go(160);
    chk("ow_acks", 16'(acks - a0), 16'd1);
    pulse_load(16'h8888, 4'b1111);
    chk("bnd_noack", {15'h0, ack}, 16'h0);
    go(193); chk("bnd_ack", {15'h0, ack}, 16'h1);
    go(195); lit("bnd_d0", 4'hE, 8'h00);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      load  = ($urandom_range(0, 11) == 0);
      data  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) data[7:4]  = 4'h0;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      @(negedge clk);
    end
    load = 1'b0; lz_en = 1'b0;

    // reset in cycle 5 of digit 2
    g = 0;
    while (!(mk > 0 && ((mk - 1) % FRAME) == 2 * SLOT + 5) && g < 100) begin
      @(negedge clk);
      g++;
    end
    lit("pre_rst_show", ~(4'b0100), seg);  // digit 2 enable must be the only low bit
    rst_n = 1'b0;
    #1;
    lit("mid_rst", 4'hF, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go(3);  lit("post_d0", 4'hE, 8'hC0);
    go(27); lit("post_d3", 4'h7, 8'hC0);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
